// File: rtl/sign_narrow.sv
// rtl/sign_narrow.sv - narrows 32-bit words to 16 bits with range check and 2-entry output buffer
//
// Purpose:
//   Converts 32-bit datapath words to 16-bit halfword/immediate form.
//   Each word is range-checked (signed or unsigned 16-bit range), flagged on
//   overflow, and pushed into a 2-entry FIFO. Accepted overflows are counted
//   in a saturating 16-bit counter.
//
// Configuration:
//   SIGN_NARROW_SAT_EN - when defined, out-of-range words saturate
//                        (0x7FFF / 0x8000 signed, 0xFFFF unsigned);
//                        otherwise they are truncated to in_data[15:0].
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   synchronous active-low reset
//   in_valid   in   1   producer presents a word
//   in_ready   out  1   unit accepts a word this cycle (occupancy < 2)
//   in_data    in   32  word to narrow
//   in_signed  in   1   1 = signed range check, 0 = unsigned
//   out_valid  out  1   head entry valid
//   out_ready  in   1   consumer takes head entry
//   out_data   out  16  narrowed result (head entry)
//   out_ovf    out  1   head entry was out of range
//   clr_count  in   1   synchronous clear of ovf_count (wins over increment)
//   ovf_count  out  16  saturating count of accepted out-of-range words

module sign_narrow (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  input  logic        clr_count,
  output logic [15:0] ovf_count
);

  // Buffer state: the head entry lives directly in the output registers,
  // the second entry in tail_*. occ counts valid entries (0..2).
  logic [1:0]  occ_q, occ_d;
  logic        valid_q, valid_d;
  logic [15:0] head_data_q, head_data_d;
  logic        head_ovf_q, head_ovf_d;
  logic [15:0] tail_data_q, tail_data_d;
  logic        tail_ovf_q, tail_ovf_d;
  logic [15:0] cnt_q, cnt_d;

  logic        push;
  logic        pop;
  logic        signed_ok;
  logic        unsigned_ok;
  logic        new_ovf;
  logic [15:0] new_data;

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = valid_q;
  assign out_data  = head_data_q;
  assign out_ovf   = head_ovf_q;
  assign ovf_count = cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = valid_q && out_ready;

  // Signed fits iff bits 31..15 are a pure sign extension of bit 15.
  assign signed_ok   = (in_data[31:15] == {17{in_data[15]}});
  assign unsigned_ok = (in_data[31:16] == 16'h0000);

  always_comb begin
    new_ovf  = in_signed ? !signed_ok : !unsigned_ok;
    new_data = in_data[15:0];
`ifdef SIGN_NARROW_SAT_EN
    if (new_ovf) begin
      if (in_signed) begin
        new_data = in_data[31] ? 16'h8000 : 16'h7FFF;
      end else begin
        new_data = 16'hFFFF;
      end
    end
`endif
  end

  always_comb begin
    occ_d       = occ_q;
    valid_d     = valid_q;
    head_data_d = head_data_q;
    head_ovf_d  = head_ovf_q;
    tail_data_d = tail_data_q;
    tail_ovf_d  = tail_ovf_q;

    case (occ_q)
      2'd0: begin
        if (push) begin
          head_data_d = new_data;
          head_ovf_d  = new_ovf;
          occ_d       = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // Head leaves and the new word takes its place directly.
          head_data_d = new_data;
          head_ovf_d  = new_ovf;
        end else if (push) begin
          tail_data_d = new_data;
          tail_ovf_d  = new_ovf;
          occ_d       = 2'd2;
        end else if (pop) begin
          // Head registers keep their stale value; out_valid masks them.
          occ_d = 2'd0;
        end
      end
      default: begin
        // Full: in_ready is low, so only a pop can happen.
        if (pop) begin
          head_data_d = tail_data_q;
          head_ovf_d  = tail_ovf_q;
          occ_d       = 2'd1;
        end
      end
    endcase

    valid_d = (occ_d != 2'd0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = 16'h0000;
    end else if (push && new_ovf && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_q       <= 2'd0;
      valid_q     <= 1'b0;
      head_data_q <= 16'h0000;
      head_ovf_q  <= 1'b0;
      tail_data_q <= 16'h0000;
      tail_ovf_q  <= 1'b0;
      cnt_q       <= 16'h0000;
    end else begin
      occ_q       <= occ_d;
      valid_q     <= valid_d;
      head_data_q <= head_data_d;
      head_ovf_q  <= head_ovf_d;
      tail_data_q <= tail_data_d;
      tail_ovf_q  <= tail_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
